intra_dc_pred_gen: RTL and testbench

//  Parametrised DC-value generator for intra prediction. Accumulates streamed top/left

---
 rtl/intra_dc_pred_gen.sv | 156 +++++++++++++++
 tb/tb_intra_dc_pred_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_dc_pred_gen.sv
// intra_dc_pred_gen: streamed top/left DC generator (whole-block or per-sub-block); optional abort port with INTRA_DC_ABORT_EN
module intra_dc_pred_gen #(
  parameter int BIT_DEPTH = 8,
  parameter int NCH = 1,
  parameter int BLK = 16,
  parameter int SUB = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      avail_t,
  input  logic                                      avail_l,
  input  logic                                      mode_sub,
  input  logic                                      ref_valid,
  input  logic [NCH*BIT_DEPTH-1:0]                  ref_t,
  input  logic [NCH*BIT_DEPTH-1:0]                  ref_l,
  output logic                                      busy,
  output logic                                      dc_valid,
  input  logic                                      dc_ready,
`ifdef INTRA_DC_ABORT_EN
  input  logic                                      abort,
`endif
  output logic [$clog2((BLK/SUB)*(BLK/SUB)):0]      dc_idx,
  output logic [NCH*BIT_DEPTH-1:0]                  dc_out
);
  localparam int NSUB = BLK / SUB;
  localparam int LB = $clog2(BLK);
  localparam int LS = $clog2(SUB);
  localparam int IW = $clog2(NSUB * NSUB) + 1;
  localparam int SW = BIT_DEPTH + LS;
  localparam int W = BIT_DEPTH + LB + 2;
  typedef enum logic [1:0] {IDLE, ACC, CALC, OUT} state_t;
  state_t state;
  logic [LB-1:0] cnt;
  logic at, al, md, kill, last, ut, ul;
  logic [SW-1:0] sum_t [NCH][NSUB];
  logic [SW-1:0] sum_l [NCH][NSUB];
  logic [NCH*BIT_DEPTH-1:0] dc_next;
  logic [W-1:0] st, sl, tx, ly, s_t, s_l;
  logic [BIT_DEPTH-1:0] val;
  int xi, yi, lb;
`ifdef INTRA_DC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign last = !md || dc_idx == IW'(NSUB * NSUB - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      dc_valid <= 1'b0;
      dc_idx <= '0;
      dc_out <= '0;
      cnt <= '0;
      at <= 1'b0;
      al <= 1'b0;
      md <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      busy <= 1'b0;
      dc_valid <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACC;
          busy <= 1'b1;
          at <= avail_t;
          al <= avail_l;
          md <= mode_sub;
          dc_idx <= '0;
          cnt <= '0;
        end
        ACC: if (ref_valid) begin
          cnt <= cnt + LB'(1);
          if (cnt == LB'(BLK - 1)) state <= CALC;
        end
        CALC: begin
          dc_out <= dc_next;
          dc_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (dc_ready) begin
          dc_valid <= 1'b0;
          if (last) begin
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            dc_idx <= dc_idx + IW'(1);
            state <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // beat k lands in sub-column/row k/SUB, so whole-block sums are just the totals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NSUB; i++) begin
          sum_t[c][i] <= '0;
          sum_l[c][i] <= '0;
        end
    end else if (kill || (state == IDLE && start)) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NSUB; i++) begin
          sum_t[c][i] <= '0;
          sum_l[c][i] <= '0;
        end
    end else if (state == ACC && ref_valid) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NSUB; i++)
          if (int'(cnt >> LS) == i) begin
            sum_t[c][i] <= sum_t[c][i] + SW'(ref_t[c*BIT_DEPTH +: BIT_DEPTH]);
            sum_l[c][i] <= sum_l[c][i] + SW'(ref_l[c*BIT_DEPTH +: BIT_DEPTH]);
          end
    end
  end
  // edge sub-blocks fall back to the other side only when their own side is missing
  always_comb begin
    dc_next = '0;
    st = '0;
    sl = '0;
    tx = '0;
    ly = '0;
    s_t = '0;
    s_l = '0;
    val = '0;
    xi = int'(dc_idx) % NSUB;
    yi = int'(dc_idx) / NSUB;
    lb = md ? LS : LB;
    ut = (md && xi == 0 && yi != 0) ? at && !al : at;
    ul = (md && xi != 0 && yi == 0) ? al && !at : al;
    for (int c = 0; c < NCH; c++) begin
      st = '0;
      sl = '0;
      tx = '0;
      ly = '0;
      for (int i = 0; i < NSUB; i++) begin
        st = st + W'(sum_t[c][i]);
        sl = sl + W'(sum_l[c][i]);
        if (i == xi) tx = W'(sum_t[c][i]);
        if (i == yi) ly = W'(sum_l[c][i]);
      end
      s_t = md ? tx : st;
      s_l = md ? ly : sl;
      val = BIT_DEPTH'(ut && ul ? (s_t + s_l + (W'(1) << lb)) >> (lb + 1) :
                       ut ? (s_t + ((W'(1) << lb) >> 1)) >> lb :
                       ul ? (s_l + ((W'(1) << lb) >> 1)) >> lb :
                       W'(1) << (BIT_DEPTH - 1));
      dc_next[c*BIT_DEPTH +: BIT_DEPTH] = val;
    end
  end
endmodule

// File: tb/tb_intra_dc_pred_gen.sv
// tb_intra_dc_pred_gen: vector table + scoreboard bench for intra_dc_pred_gen (BLK=8, SUB=4, NCH=2)
module tb_intra_dc_pred_gen;
  localparam int BD = 8;
  localparam int NCH = 2;
  localparam int BLK = 8;
  localparam int SUB = 4;
  localparam int NSUB = 2;
  localparam int NO = NSUB * NSUB;
  localparam int IW = 3;
  logic clk = 0, rst_n = 0, start = 0, avail_t = 0, avail_l = 0, mode_sub = 0;
  logic ref_valid = 0, dc_ready = 0, busy, dc_valid;
  logic [NCH*BD-1:0] ref_t = '0, ref_l = '0, dc_out;
  logic [IW-1:0] dc_idx;
`ifdef INTRA_DC_ABORT_EN
  logic abort = 0;
`endif
  always #5 clk = ~clk;
  intra_dc_pred_gen #(.BIT_DEPTH(BD), .NCH(NCH), .BLK(BLK), .SUB(SUB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .avail_t(avail_t), .avail_l(avail_l),
    .mode_sub(mode_sub), .ref_valid(ref_valid), .ref_t(ref_t), .ref_l(ref_l),
    .busy(busy), .dc_valid(dc_valid), .dc_ready(dc_ready),
`ifdef INTRA_DC_ABORT_EN
    .abort(abort),
`endif
    .dc_idx(dc_idx), .dc_out(dc_out));
  typedef struct {
    bit m, at, al;
    int pat, gap;
    bit rr, use_e0;
    logic [31:0] e0;
  } vec_t;
  typedef struct {
    logic [IW-1:0] idx;
    logic [NCH*BD-1:0] dc;
  } exp_t;
  exp_t sb[$];
  vec_t vt[14];
  int n_cmp = 0, n_err = 0, gc = 0;
  bit man = 0, rnd = 0, mon_en = 1, pst = 0;
  logic [7:0] pt[NCH][BLK], pl[NCH][BLK];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit m, bit at, bit al, int pat, int gap, bit rr, bit ue, logic [31:0] e0);
    vec_t v;
    v.m = m; v.at = at; v.al = al; v.pat = pat; v.gap = gap; v.rr = rr; v.use_e0 = ue; v.e0 = e0;
    return v;
  endfunction

  task automatic fill(int pat);
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < BLK; k++) begin
        if (pat == 0) begin pt[c][k] = 100; pl[c][k] = 50; end
        else if (pat == 1 && c == 0) begin pt[c][k] = k < 4 ? 10 : 200; pl[c][k] = k < 4 ? 30 : 90; end
        else if (pat == 1) begin pt[c][k] = 8'(3 + k * 31); pl[c][k] = 8'(250 - k * 17); end
        else if (pat == 2) begin pt[c][k] = 8'($urandom_range(0, 255)); pl[c][k] = 8'($urandom_range(0, 255)); end
        else begin pt[c][k] = 255; pl[c][k] = 255; end
      end
  endtask

  function automatic logic [7:0] model(int c, bit m, bit at, bit al, int idx);
    int t = 0, l = 0, n, x, y;
    bit ut, ul;
    if (!m) begin
      for (int k = 0; k < BLK; k++) begin t += pt[c][k]; l += pl[c][k]; end
      n = BLK; ut = at; ul = al;
    end else begin
      x = idx % NSUB; y = idx / NSUB; n = SUB;
      for (int k = 0; k < SUB; k++) begin t += pt[c][x*SUB+k]; l += pl[c][y*SUB+k]; end
      if (x > 0 && y == 0) begin ut = at; ul = al && !at; end
      else if (x == 0 && y > 0) begin ul = al; ut = at && !al; end
      else begin ut = at; ul = al; end
    end
    if (ut && ul) return 8'((t + l + n) / (2 * n));
    if (ut) return 8'((t + n / 2) / n);
    if (ul) return 8'((l + n / 2) / n);
    return 8'd128;
  endfunction

  task automatic push_exp(vec_t v);
    exp_t e;
    for (int i = 0; i < (v.m ? NO : 1); i++) begin
      e.idx = IW'(i);
      e.dc[7:0] = v.use_e0 ? v.e0[i*8 +: 8] : model(0, v.m, v.at, v.al, i);
      e.dc[15:8] = model(1, v.m, v.at, v.al, i);
      sb.push_back(e);
    end
  endtask

  task automatic start_block(vec_t v);
    @(posedge clk); #1;
    start = 1; avail_t = v.at; avail_l = v.al; mode_sub = v.m;
    @(posedge clk); #1;
    start = 0; avail_t = !v.at; avail_l = !v.al; mode_sub = !v.m;
    chk("busy_start", busy, 1);
    for (int k = 0; k < BLK; k++) begin
      ref_valid = 1;
      for (int c = 0; c < NCH; c++) begin ref_t[c*BD +: BD] = pt[c][k]; ref_l[c*BD +: BD] = pl[c][k]; end
      @(posedge clk); #1;
      ref_valid = 0; ref_t = 16'($urandom); ref_l = 16'($urandom);
      if (k < BLK - 1) repeat (v.gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !busy;
    end
    chk("drain", ok, 1);
    if (!ok) sb.delete();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !dc_valid; i++) @(negedge clk);
    chk("wait_valid", dc_valid, 1);
  endtask

  task automatic run_block(vec_t v);
    fill(v.pat);
    push_exp(v);
    rnd = v.rr;
    start_block(v);
    @(negedge clk) chk("lat_calc", dc_valid, 0);
    @(negedge clk) chk("lat_first", dc_valid, 1);
    drain();
  endtask

  always @(posedge clk) begin
    #1;
    if (!man) dc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // every visible DC must match the scoreboard head, including every stalled cycle
  always @(negedge clk) begin
    if (!mon_en) begin
      pst = 0; gc = 0;
    end else begin
      if (pst) chk("hold_valid", dc_valid, 1);
      if (gc == 1) begin chk("next_valid", dc_valid, 1); gc = 0; end
      if (gc == 2) begin chk("recalc_gap", dc_valid, 0); gc = 1; end
      if (dc_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_dc: got idx %0d dc %0h, none expected", dc_idx, dc_out);
        end else begin
          chk("dc_idx", dc_idx, sb[0].idx);
          chk("dc_out", dc_out, sb[0].dc);
          if (dc_ready) begin
            void'(sb.pop_front());
            if (sb.size() > 0) gc = 2;
          end
        end
      end
      pst = dc_valid && !dc_ready;
    end
  end

  initial begin
    vt[0]  = mk(0, 1, 1, 0, 0, 0, 1, {24'd0, 8'd75});
    vt[1]  = mk(1, 1, 1, 1, 0, 0, 1, {8'd145, 8'd90, 8'd200, 8'd20});
    vt[2]  = mk(1, 0, 1, 1, 0, 0, 1, {8'd90, 8'd90, 8'd30, 8'd30});
    vt[3]  = mk(1, 0, 0, 1, 0, 0, 1, {4{8'd128}});
    vt[4]  = mk(1, 1, 0, 1, 0, 0, 1, {8'd200, 8'd10, 8'd200, 8'd10});
    vt[5]  = mk(1, 1, 1, 1, 2, 1, 1, {8'd145, 8'd90, 8'd200, 8'd20});
    vt[6]  = mk(0, 1, 0, 2, 0, 1, 0, 0);
    vt[7]  = mk(0, 0, 1, 2, 1, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 2, 0, 1, 0, 0);
    vt[9]  = mk(1, 1, 1, 2, 1, 1, 0, 0);
    vt[10] = mk(1, 1, 0, 2, 0, 1, 0, 0);
    vt[11] = mk(1, 0, 1, 2, 0, 1, 0, 0);
    vt[12] = mk(0, 1, 1, 3, 0, 0, 1, {24'd0, 8'd255});
    vt[13] = mk(1, 1, 1, 3, 0, 1, 1, {4{8'd255}});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", dc_valid, 0);
    chk("rst_idx", dc_idx, 0);
    chk("rst_dc", dc_out, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) run_block(vt[i]);
    // stall on idx1 for five cycles with a start pulse that must be ignored
    fill(1);
    push_exp(vt[1]);
    man = 1; dc_ready = 0;
    start_block(vt[1]);
    wait_valid();
    @(posedge clk); #1 dc_ready = 1;
    @(posedge clk); #1 dc_ready = 0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = i == 0; mode_sub = 0; avail_t = 0; avail_l = 0;
    end
    chk("busy_stall", busy, 1);
    chk("idx_stall", dc_idx, 1);
    man = 0;
    drain();
    // beats while idle must not start or disturb anything
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ref_valid = 1; ref_t = 16'hFFFF; ref_l = 16'hFFFF;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", dc_valid, 0);
    end
    ref_valid = 0;
    run_block(vt[4]);
    run_block(vt[5]);
    // asynchronous reset in the middle of accumulation
    @(posedge clk); #1;
    start = 1; mode_sub = 1; avail_t = 1; avail_l = 1;
    @(posedge clk); #1;
    start = 0; ref_valid = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", dc_valid, 0);
    chk("mid_rst_idx", dc_idx, 0);
    chk("mid_rst_dc", dc_out, 0);
    ref_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 6; i < 14; i++) run_block(vt[i]);
`ifdef INTRA_DC_ABORT_EN
    mon_en = 0; man = 1; dc_ready = 0;
    fill(1);
    start_block(vt[1]);
    wait_valid();
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", dc_valid, 0);
    man = 0; mon_en = 1;
    run_block(vt[2]);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
